// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data (data-first, alternates under contention); min 3 cycles/access.
// Requests are levels held until the one-cycle response pulse; stall_if/stall_d hold the pipeline meanwhile.
// Define MEM_ARB_TIMEOUT_EN to force-complete an unacked access after TIMEOUT wait cycles and raise sticky bus_err.
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall_if,
  output logic              stall_d,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  state_t   state;
  mem_cmd_t cmd_q, cmd_d;
  logic     last_data, owner_d;
  logic     d_any, grant_d, timeout_hit, finish;

  assign d_any   = d_rd | d_wr;
  // Fetch only beats a contending data request right after a data grant.
  assign grant_d = d_any & (~if_req | ~last_data);
  assign finish  = (state == S_WAIT) & (mem_ack | timeout_hit);

  always_comb begin
    cmd_d       = '0;
    cmd_d.we    = grant_d & d_wr;
    cmd_d.addr  = grant_d ? d_addr : if_addr;
    cmd_d.wdata = grant_d ? d_wdata : '0;
  end

  assign mem_we    = cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign stall_if  = if_req & ~if_valid;
  assign stall_d   = d_any & ~d_done;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Fires on the TIMEOUT-th ack-less WAIT cycle; a coincident ack still wins.
  assign timeout_hit = (state == S_WAIT) & (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      if (state != S_WAIT) begin
        wait_cnt <= '0;
      end else if (!mem_ack && !timeout_hit) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (timeout_hit && !mem_ack) begin
        bus_err <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      last_data <= 1'b0;
      owner_d   <= 1'b0;
      mem_req   <= 1'b0;
      cmd_q     <= '0;
      if_valid  <= 1'b0;
      d_done    <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (if_req || d_any) begin
            mem_req   <= 1'b1;
            cmd_q     <= cmd_d;
            owner_d   <= grant_d;
            last_data <= grant_d;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (finish) begin
            mem_req <= 1'b0;
            state   <= S_RESP;
            if (owner_d) begin
              d_done <= 1'b1;
              // Acked writes keep the last load value; a timed-out access returns zero.
              if (!cmd_q.we || !mem_ack) begin
                d_rdata <= mem_ack ? mem_rdata : '0;
              end
            end else begin
              if_valid <= 1'b1;
              if_rdata <= mem_ack ? mem_rdata : '0;
            end
          end
        end
        S_RESP: begin
          if_valid <= 1'b0;
          d_done   <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic against a transaction model.
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, d_rd, d_wr, mem_ack;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic          if_valid, d_done, stall_if, stall_d, mem_req, mem_we, bus_err;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .stall_if(stall_if), .stall_d(stall_d),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0; mem_ack = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0; mem_ack = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    #2;
    n_tests++; if ({mem_req, mem_we, if_valid, d_done, bus_err} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {mem_req, mem_we, if_valid, d_done, bus_err}); end
    n_tests++; if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, if_rdata, d_rdata}); end
    tick();
    rst_n = 1'b1;
    tick();
    n_tests++; if ({mem_req, stall_if, stall_d} !== 3'b0) begin n_fail++; $display("FAIL reset_idle: got %b want 000", {mem_req, stall_if, stall_d}); end
  endtask

  task automatic test_single_fetch();
    apply_reset();
    if_req = 1'b1; if_addr = 16'h0010;
    tick();
    n_tests++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0010}) begin n_fail++; $display("FAIL fetch_issue: got req=%b we=%b addr=%h want 1 0 0010", mem_req, mem_we, mem_addr); end
    n_tests++; if (stall_if !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_c1: got %b want 1", stall_if); end
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0;
    n_tests++; if ({mem_req, if_valid, d_done} !== 3'b010) begin n_fail++; $display("FAIL fetch_resp: got req/valid/done=%b want 010", {mem_req, if_valid, d_done}); end
    n_tests++; if (if_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fetch_rdata: got %h want deadbeef", if_rdata); end
    n_tests++; if (stall_if !== 1'b0) begin n_fail++; $display("FAIL fetch_stall_c2: got %b want 0", stall_if); end
    if_req = 1'b0;
    tick();
    n_tests++; if ({mem_req, if_valid} !== 2'b00) begin n_fail++; $display("FAIL fetch_after: got req/valid=%b want 00", {mem_req, if_valid}); end
  endtask

  task automatic test_contention();
    logic want_d;
    apply_reset();
    if_req = 1'b1; if_addr = 16'h0200;
    d_rd = 1'b1;   d_addr = 16'h0300;
    for (int g = 0; g < 4; g++) begin
      want_d = (g % 2 == 0);
      tick();
      n_tests++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, (want_d ? 16'h0300 : 16'h0200)}) begin n_fail++; $display("FAIL contention_grant%0d: got req=%b we=%b addr=%h want_data=%b", g, mem_req, mem_we, mem_addr, want_d); end
      mem_ack = 1'b1; mem_rdata = DW'(g);
      tick();
      mem_ack = 1'b0;
      n_tests++; if ({d_done, if_valid, mem_req} !== {want_d, ~want_d, 1'b0}) begin n_fail++; $display("FAIL contention_resp%0d: got done/valid/req=%b want %b", g, {d_done, if_valid, mem_req}, {want_d, ~want_d, 1'b0}); end
      tick();
      n_tests++; if ({mem_req, d_done, if_valid} !== 3'b000) begin n_fail++; $display("FAIL contention_idle%0d: got req/done/valid=%b want 000", g, {mem_req, d_done, if_valid}); end
    end
    if_req = 1'b0; d_rd = 1'b0;
    tick();
  endtask

  task automatic test_store_wait();
    logic [DW-1:0] prev;
    prev = d_rdata;
    d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 32'h12345678;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_tests++; if ({mem_req, mem_we, mem_addr, mem_wdata, d_done, stall_d} !== {1'b1, 1'b1, 16'h0100, 32'h12345678, 1'b0, 1'b1}) begin n_fail++; $display("FAIL store_wait%0d: got req=%b we=%b addr=%h wdata=%h done=%b stall=%b", i, mem_req, mem_we, mem_addr, mem_wdata, d_done, stall_d); end
      if (i < 4) tick();
    end
    mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
    tick();
    mem_ack = 1'b0;
    n_tests++; if ({d_done, mem_req, stall_d} !== 3'b100) begin n_fail++; $display("FAIL store_done: got done/req/stall=%b want 100", {d_done, mem_req, stall_d}); end
    n_tests++; if (d_rdata !== prev) begin n_fail++; $display("FAIL store_rdata: got %h want %h", d_rdata, prev); end
    d_wr = 1'b0;
    tick();
    n_tests++; if (d_done !== 1'b0) begin n_fail++; $display("FAIL store_pulse: got %b want 0", d_done); end
  endtask

  task automatic test_illegal();
    d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0044; d_wdata = 32'h0000CAFE;
    tick();
    n_tests++; if ({mem_req, mem_we, mem_wdata} !== {1'b1, 1'b1, 32'h0000CAFE}) begin n_fail++; $display("FAIL illegal_we: got req=%b we=%b wdata=%h want 1 1 0000cafe", mem_req, mem_we, mem_wdata); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_tests++; if (d_done !== 1'b1) begin n_fail++; $display("FAIL illegal_done: got %b want 1", d_done); end
    d_rd = 1'b0; d_wr = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    d_rd = 1'b1; d_addr = 16'h0055;
    tick(); tick();
    n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL midrst_wait: got %b want 1", mem_req); end
    rst_n = 1'b0;
    #1;
    n_tests++; if ({mem_req, d_done} !== 2'b00) begin n_fail++; $display("FAIL midrst_drop: got req/done=%b want 00", {mem_req, d_done}); end
    d_rd = 1'b0;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    rst_n = 1'b1;
    tick();
    n_tests++; if ({mem_req, d_done, if_valid} !== 3'b000) begin n_fail++; $display("FAIL midrst_release: got req/done/valid=%b want 000", {mem_req, d_done, if_valid}); end
    // Data was the last grant before reset; a cleared arbiter must pick data again.
    if_req = 1'b1; if_addr = 16'h0066; d_rd = 1'b1; d_addr = 16'h0077;
    tick();
    n_tests++; if ({mem_req, mem_addr} !== {1'b1, 16'h0077}) begin n_fail++; $display("FAIL midrst_regrant: got req=%b addr=%h want 1 0077", mem_req, mem_addr); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0; if_req = 1'b0; d_rd = 1'b0;
    tick();
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    if_req = 1'b1; if_addr = 16'h0020;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    tick();
    mem_ack = 1'b0;
    tick();
    for (int c = 1; c <= 4; c++) begin
      if (c == 1) tick();
      n_tests++; if ({mem_req, if_valid} !== 2'b10) begin n_fail++; $display("FAIL timeout_wait%0d: got req/valid=%b want 10", c, {mem_req, if_valid}); end
      tick();
    end
    n_tests++; if ({if_valid, mem_req, bus_err, if_rdata} !== {3'b101, 32'h0}) begin n_fail++; $display("FAIL timeout_resp: got valid=%b req=%b err=%b rdata=%h want 1 0 1 0", if_valid, mem_req, bus_err, if_rdata); end
    if_req = 1'b0;
    tick(); tick();
    n_tests++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b want 1", bus_err); end
    apply_reset();
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %b want 0", bus_err); end
  endtask
`endif

  task automatic test_random();
    logic [DW-1:0] mem_m [logic [AW-1:0]];
    logic          pend_f, pend_d, last_d, win_d, exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_if, exp_d, rd_val;
    int            op, delay;
    apply_reset();
    mem_m.delete();
    pend_f = 1'b0; pend_d = 1'b0; last_d = 1'b0; exp_if = '0; exp_d = '0;
    for (int it = 0; it < 60; it++) begin
      if (!pend_f && $urandom_range(0, 1) == 1) begin
        pend_f = 1'b1; if_addr = AW'($urandom_range(0, 7) * 4);
      end
      if (!pend_d && ($urandom_range(0, 1) == 1 || !pend_f)) begin
        pend_d = 1'b1; op = $urandom_range(0, 2);
        d_rd = (op != 1); d_wr = (op != 0);
        d_addr = AW'($urandom_range(0, 7) * 4); d_wdata = $urandom;
      end
      if_req = pend_f;
      win_d = pend_d && (!pend_f || !last_d);
      last_d = win_d;
      exp_we = win_d && d_wr;
      exp_addr = win_d ? d_addr : if_addr;
      mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      tick();
      mem_ack = 1'b0;
      delay = $urandom_range(0, 3);
      for (int w = 0; w <= delay; w++) begin
        n_tests++; if ({mem_req, mem_we, mem_addr, if_valid, d_done, stall_if, stall_d} !== {1'b1, exp_we, exp_addr, 2'b00, pend_f, pend_d}) begin n_fail++; $display("FAIL rnd_issue it=%0d w=%0d: got req=%b we=%b addr=%h v=%b d=%b st=%b%b want we=%b addr=%h", it, w, mem_req, mem_we, mem_addr, if_valid, d_done, stall_if, stall_d, exp_we, exp_addr); end
        if (exp_we) begin
          n_tests++; if (mem_wdata !== d_wdata) begin n_fail++; $display("FAIL rnd_wdata it=%0d: got %h want %h", it, mem_wdata, d_wdata); end
        end
        if (w < delay) begin
          mem_rdata = $urandom;
          tick();
        end
      end
      if (exp_we) begin
        mem_m[d_addr] = d_wdata;
        rd_val = $urandom;
      end else begin
        rd_val = mem_m.exists(exp_addr) ? mem_m[exp_addr] : {~exp_addr, exp_addr};
        if (win_d) exp_d = rd_val; else exp_if = rd_val;
      end
      mem_ack = 1'b1; mem_rdata = rd_val;
      tick();
      n_tests++; if ({d_done, if_valid, mem_req} !== {win_d, ~win_d, 1'b0}) begin n_fail++; $display("FAIL rnd_resp it=%0d: got done/valid/req=%b want %b", it, {d_done, if_valid, mem_req}, {win_d, ~win_d, 1'b0}); end
      n_tests++; if ({if_rdata, d_rdata} !== {exp_if, exp_d}) begin n_fail++; $display("FAIL rnd_rdata it=%0d: got if=%h d=%h want if=%h d=%h", it, if_rdata, d_rdata, exp_if, exp_d); end
      if (win_d) begin pend_d = 1'b0; d_rd = 1'b0; d_wr = 1'b0; end
      else begin pend_f = 1'b0; if_req = 1'b0; end
      mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      tick();
      mem_ack = 1'b0;
      n_tests++; if ({mem_req, if_valid, d_done, if_rdata, d_rdata} !== {3'b000, exp_if, exp_d}) begin n_fail++; $display("FAIL rnd_idle it=%0d: got req/v/d=%b if=%h d=%h", it, {mem_req, if_valid, d_done}, if_rdata, d_rdata); end
    end
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL rnd_bus_err: got %b want 0", bus_err); end
    if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_store_wait();
    test_illegal();
    test_reset_mid();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single-ported memory between the instruction-fetch stage and the data-memory stage. The data-memory stage issues load, store, push and pop accesses, as flagged by the decoder's `mem_rd`/`mem_wr`.
- Each access is sequenced as request → wait-for-ack → response.
- The block generates per-requester stall signals for the pipeline.
- Arbitration is data-first, with anti-starvation alternation for fetch.

## Interface
Parameters:
- `ADDR_W`, 16, memory address width
- `DATA_W`, 32, memory data width
- `TIMEOUT`, 255, ack-wait limit in cycles; used only with the timeout feature (see Configuration)

Ports (all synchronous to `clk`):
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request; level, held until `if_valid`
- `if_addr`  in  ADDR_W  fetch address
- `if_valid`  out  1  one-cycle fetch response pulse
- `if_rdata`  out  DATA_W  fetched word; valid while `if_valid`
- `d_rd`  in  1  data read request (load/pop); level
- `d_wr`  in  1  data write request (store/push); level
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  write data
- `d_done`  out  1  one-cycle data response pulse
- `d_rdata`  out  DATA_W  read data; valid while `d_done`
- `stall_if`  out  1  `if_req & ~if_valid` (combinational)
- `stall_d`  out  1  `(d_rd | d_wr) & ~d_done` (combinational)
- `mem_req`  out  1  memory request; registered
- `mem_we`  out  1  write enable; registered
- `mem_addr`  out  ADDR_W  registered address
- `mem_wdata`  out  DATA_W  registered write data
- `mem_ack`  in  1  memory completion; one-cycle pulse, may arrive in any cycle once `mem_req` is high
- `mem_rdata`  in  DATA_W  read data; valid with `mem_ack`
- `bus_err`  out  1  sticky timeout error

## Operation
States:
- **IDLE**
  - Samples requests.
  - Selects a winner.
  - Registers `mem_req`=1 together with `mem_we`, `mem_addr` and `mem_wdata` from the winner.
  - Records the owner, then goes to WAIT.
  - With no request pending, stays in IDLE with `mem_req`=0.
- **WAIT**
  - Holds `mem_req` and the captured fields stable.
  - When `mem_ack`=1: captures `mem_rdata` into the owner's rdata register, clears `mem_req`, goes to RESP.
- **RESP**
  - Pulses `if_valid` or `d_done` for the owner for exactly one cycle.
  - Ignores all requests.
  - Goes to IDLE next cycle. The requester must drop or replace its request on seeing the pulse, so no duplicate access is issued.

Arbitration (IDLE only):
- If only one side requests, it wins.
- If both request, data wins unless `last_data`=1, in which case fetch wins.
- `last_data` updates on each grant: set to 1 on a data grant, 0 on a fetch grant.
- Net effect: under continuous contention, grants alternate data/fetch.

Request handling:
- `d_rd`=1 with `d_wr`=1 is illegal; it is treated as a write (`mem_we`=1).
- Addresses and write data are captured only at grant. Requester changes during WAIT/RESP have no effect.
- `if_rdata`/`d_rdata` hold their last value until the next capture for that requester.
- For writes, `d_rdata` is not updated.

## Timing
- Reset (asynchronous, immediate):
  - State → IDLE; `last_data`=0.
  - `mem_req`, `mem_we`, `if_valid`, `d_done`, `bus_err` = 0.
  - `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` = 0.
  - Reset asserted mid-access drops `mem_req` in the same cycle. No response pulse is ever generated for the aborted access.
- Latency, with request sampled at cycle 0 in IDLE:
  - `mem_req`=1 at cycle 1.
  - If `mem_ack` is sampled at cycle k ≥ 1: response pulse and `mem_req`=0 at cycle k+1, IDLE at k+2.
  - Minimum 3 cycles per access; throughput is one access per 3 cycles with zero-wait memory.
- A request rising during RESP is sampled at the following IDLE cycle.
- A `mem_ack` arriving in IDLE or RESP is ignored.

## Configuration
- Macro `MEM_ARB_TIMEOUT_EN`, defined:
  - An 8+-bit counter clears on entering WAIT and increments each WAIT cycle without ack.
  - When it reaches `TIMEOUT`, the arbiter forces completion:
    - `mem_req` drops;
    - state goes to RESP;
    - the owner's rdata captures 0;
    - `bus_err` is set.
  - `bus_err` stays set until reset.
  - An ack in the same cycle the counter reaches `TIMEOUT` is a normal completion with no error.
- Macro not defined: no counter; WAIT lasts indefinitely; `bus_err` is tied to 0.

## Test plan
- **Single fetch:** after reset, `if_req`=1, `if_addr`=0x0010, ack in cycle 1 with `mem_rdata`=0xDEADBEEF. Required: `mem_req` high in cycle 1 only; `if_valid`=1 with `if_rdata`=0xDEADBEEF in cycle 2; `stall_if` low from cycle 2.
- **Contention alternation:** `if_req` and `d_rd` held high continuously, ack always 1 cycle after `mem_req`. Required: grants go D, F, D, F; `mem_we`=0 throughout; no duplicate grants.
- **Store with wait states:** `d_wr`=1, `d_addr`=0x0100, `d_wdata`=0x12345678, ack delayed 5 cycles. Required: `mem_we`=1 and fields stable for all 5 cycles; `d_done` one cycle after ack; `d_rdata` unchanged.
- **Illegal request:** `d_rd`=`d_wr`=1. Required: access issued with `mem_we`=1.
- **Reset mid-access:** `rst_n` low during WAIT. Required: `mem_req`=0 immediately; no `d_done`; state IDLE after release.
- **Timeout (`MEM_ARB_TIMEOUT_EN` defined, `TIMEOUT`=4):** no ack. Required: response pulse after 4 WAIT cycles; rdata=0; `bus_err`=1 and sticky until reset.
